// File: rtl/inst_mem_pipe.sv
// Instruction store for the pipelined ARM core: 1- or 2-cycle registered fetch
// with stall hold, NOP substitution on bad fetches, and a byte-enabled load port.
module inst_mem_pipe #(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DEPTH    = 256,
  parameter int unsigned       READ_LAT = 1,
  parameter logic [DATA_W-1:0] NOP_WORD = 32'hE1A00000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_W-1:0]     inst_address,
  input  logic                  inst_read,
  input  logic                  inst_write,
  input  logic [DATA_W-1:0]     inst_write_data,
  input  logic [DATA_W/8-1:0]   inst_byte_en,
  input  logic                  stall,
  output logic [DATA_W-1:0]     inst_out,
  output logic                  inst_valid,
  output logic                  inst_err,
  output logic                  wr_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned BE_W  = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [IDX_W-1:0]  idx;
  logic [ADDR_W-1:0] upper;
  logic              bad;

  always_comb begin
    idx   = inst_address[IDX_W+1:2];
    upper = inst_address >> (IDX_W + 2);
    bad   = (inst_address[1:0] != 2'b00) || (upper != '0);
  end

  // Array is deliberately left without reset so program contents survive it.
  always_ff @(posedge clk) begin
    if (inst_write && !bad) begin
      for (int unsigned b = 0; b < BE_W; b++) begin
        if (inst_byte_en[b]) mem[idx][8*b +: 8] <= inst_write_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_err <= 1'b0;
    else        wr_err <= inst_write && bad;
  end

  logic [DATA_W-1:0] s1_data;
  logic              s1_valid;
  logic              s1_err;

  // A bubble keeps the previous data so the output holds its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_data  <= NOP_WORD;
      s1_valid <= 1'b0;
      s1_err   <= 1'b0;
    end else if (!stall) begin
      if (inst_read) begin
        s1_data  <= bad ? NOP_WORD : mem[idx];
        s1_valid <= 1'b1;
        s1_err   <= bad;
      end else begin
        s1_valid <= 1'b0;
        s1_err   <= 1'b0;
      end
    end
  end

  if (READ_LAT == 2) begin : g_lat2
    logic [DATA_W-1:0] s2_data;
    logic              s2_valid;
    logic              s2_err;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s2_data  <= NOP_WORD;
        s2_valid <= 1'b0;
        s2_err   <= 1'b0;
      end else if (!stall) begin
        if (s1_valid) s2_data <= s1_data;
        s2_valid <= s1_valid;
        s2_err   <= s1_err;
      end
    end

    assign inst_out   = s2_data;
    assign inst_valid = s2_valid;
    assign inst_err   = s2_err;
  end else begin : g_lat1
    assign inst_out   = s1_data;
    assign inst_valid = s1_valid;
    assign inst_err   = s1_err;
  end

endmodule

// File: tb/tb_inst_mem_pipe.sv
// Bench for inst_mem_pipe: READ_LAT=1 and READ_LAT=2 instances share stimulus and
// are checked every cycle against a token-stream model, plus directed literal checks.
module tb_inst_mem_pipe;

  localparam logic [31:0] NOP = 32'hE1A00000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] inst_address;
  logic        inst_read;
  logic        inst_write;
  logic [31:0] inst_write_data;
  logic [3:0]  inst_byte_en;
  logic        stall;

  logic [31:0] out1, out2;
  logic        v1, v2, e1, e2, we1, we2;

  always #5 clk = ~clk;

  inst_mem_pipe #(.READ_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .inst_address(inst_address), .inst_read(inst_read),
    .inst_write(inst_write), .inst_write_data(inst_write_data), .inst_byte_en(inst_byte_en),
    .stall(stall), .inst_out(out1), .inst_valid(v1), .inst_err(e1), .wr_err(we1)
  );

  inst_mem_pipe #(.READ_LAT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .inst_address(inst_address), .inst_read(inst_read),
    .inst_write(inst_write), .inst_write_data(inst_write_data), .inst_byte_en(inst_byte_en),
    .stall(stall), .inst_out(out2), .inst_valid(v2), .inst_err(e2), .wr_err(we2)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_on = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Model: each unstalled edge emits one token (fetch result or bubble); an
  // instance of latency L shows token u-L+1, where u counts unstalled edges.
  logic [31:0] mem_m [256];
  logic [31:0] sh_data [0:8191];
  bit          t_valid [0:8191];
  bit          t_err   [0:8191];
  int          u;
  bit          exp_wr_err;

  always @(posedge clk or negedge rst_n) begin
    bit m_bad;
    if (!rst_n) begin
      u          = 0;
      sh_data[0] = NOP;
      t_valid[0] = 0;
      t_err[0]   = 0;
      exp_wr_err = 0;
    end else begin
      m_bad      = (inst_address % 4 != 0) || (inst_address >= 32'd1024);
      exp_wr_err = inst_write && m_bad;
      if (!stall) begin
        u++;
        if (inst_read) begin
          t_valid[u] = 1;
          t_err[u]   = m_bad;
          sh_data[u] = m_bad ? NOP : mem_m[inst_address / 4];
        end else begin
          t_valid[u] = 0;
          t_err[u]   = 0;
          sh_data[u] = sh_data[u-1];
        end
      end
      if (inst_write && !m_bad) begin
        for (int b = 0; b < 4; b++)
          if (inst_byte_en[b]) mem_m[inst_address / 4][8*b +: 8] = inst_write_data[8*b +: 8];
      end
    end
  end

  always @(negedge clk) begin
    int k1, k2;
    if (cmp_on) begin
      k1 = u;
      k2 = (u >= 1) ? u - 1 : 0;
      chk("lat1_out",    out1, sh_data[k1]);
      chk("lat1_valid",  {31'b0, v1}, {31'b0, t_valid[k1]});
      chk("lat1_err",    {31'b0, e1}, {31'b0, t_err[k1]});
      chk("lat1_wr_err", {31'b0, we1}, {31'b0, exp_wr_err});
      chk("lat2_out",    out2, sh_data[k2]);
      chk("lat2_valid",  {31'b0, v2}, {31'b0, t_valid[k2]});
      chk("lat2_err",    {31'b0, e2}, {31'b0, t_err[k2]});
      chk("lat2_wr_err", {31'b0, we2}, {31'b0, exp_wr_err});
    end
  end

  task automatic step(input logic rd, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [3:0] be, input logic st);
    inst_read       = rd;
    inst_write      = wr;
    inst_address    = addr;
    inst_write_data = wd;
    inst_byte_en    = be;
    stall           = st;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int r;
    rst_n = 0;
    inst_read = 0; inst_write = 0; inst_address = '0;
    inst_write_data = '0; inst_byte_en = '0; stall = 0;
    repeat (2) @(negedge clk);
    chk("reset_out1",   out1, NOP);
    chk("reset_valid1", {31'b0, v1}, 32'd0);
    chk("reset_out2",   out2, NOP);
    chk("reset_wr_err", {31'b0, we2}, 32'd0);
    rst_n = 1;
    cmp_on = 1;

    for (int i = 0; i < 256; i++) step(0, 1, i * 4, $urandom, 4'hF, 0);

    // Load and fetch
    step(0, 1, 32'h0, 32'hE3A01005, 4'hF, 0);
    step(0, 1, 32'h4, 32'hE2811001, 4'hF, 0);
    step(0, 1, 32'h8, 32'hEAFFFFFE, 4'hF, 0);
    step(1, 0, 32'h0, '0, 4'h0, 0);
    chk("load_l1_w0", out1, 32'hE3A01005);
    chk("load_l1_v0", {31'b0, v1}, 32'd1);
    chk("load_l1_e0", {31'b0, e1}, 32'd0);
    chk("load_l2_nv", {31'b0, v2}, 32'd0);
    step(1, 0, 32'h4, '0, 4'h0, 0);
    chk("load_l1_w1", out1, 32'hE2811001);
    chk("load_l2_w0", out2, 32'hE3A01005);
    step(1, 0, 32'h8, '0, 4'h0, 0);
    chk("load_l1_w2", out1, 32'hEAFFFFFE);
    chk("load_l2_w1", out2, 32'hE2811001);
    step(0, 0, 32'h0, '0, 4'h0, 0);
    chk("load_l1_bub_v", {31'b0, v1}, 32'd0);
    chk("load_l1_hold",  out1, 32'hEAFFFFFE);
    chk("load_l2_w2",    out2, 32'hEAFFFFFE);
    chk("load_l2_v2",    {31'b0, v2}, 32'd1);
    step(0, 0, 32'h0, '0, 4'h0, 0);
    chk("load_l2_bub_v", {31'b0, v2}, 32'd0);

    // Byte-enable merge
    step(0, 1, 32'h10, 32'h11223344, 4'hF, 0);
    step(0, 1, 32'h10, 32'hAABBCCDD, 4'b0101, 0);
    step(1, 0, 32'h10, '0, 4'h0, 0);
    chk("be_merge", out1, 32'h11BB33DD);

    // Error handling
    step(1, 0, 32'h6, '0, 4'h0, 0);
    chk("mis_out", out1, NOP);
    chk("mis_v",   {31'b0, v1}, 32'd1);
    chk("mis_e",   {31'b0, e1}, 32'd1);
    step(1, 0, 32'h400, '0, 4'h0, 0);
    chk("oor_out", out1, NOP);
    chk("oor_e",   {31'b0, e1}, 32'd1);
    chk("mis_l2_e", {31'b0, e2}, 32'd1);
    step(0, 1, 32'h2, 32'h12345678, 4'hF, 0);
    chk("wr_err_rise", {31'b0, we1}, 32'd1);
    step(0, 0, 32'h0, '0, 4'h0, 0);
    chk("wr_err_fall", {31'b0, we1}, 32'd0);
    step(1, 0, 32'h0, '0, 4'h0, 0);
    chk("bad_wr_intact", out1, 32'hE3A01005);

    // Stall (READ_LAT=2 view)
    step(1, 0, 32'h0, '0, 4'h0, 0);
    step(1, 0, 32'h4, '0, 4'h0, 0);
    chk("stall_pre_l2", out2, 32'hE3A01005);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 32'h8, '0, 4'h0, 1);
      chk("stall_l2_out", out2, 32'hE3A01005);
      chk("stall_l2_v",   {31'b0, v2}, 32'd1);
      chk("stall_l1_out", out1, 32'hE2811001);
    end
    step(0, 0, 32'h8, '0, 4'h0, 0);
    chk("stall_resume_l2", out2, 32'hE2811001);
    chk("stall_resume_v",  {31'b0, v2}, 32'd1);
    step(0, 0, 32'h8, '0, 4'h0, 0);
    chk("stall_no_0x8_v",  {31'b0, v2}, 32'd0);
    chk("stall_no_0x8_d",  out2, 32'hE2811001);

    // Collision: read-before-write
    step(1, 1, 32'h0, 32'hDEADBEEF, 4'hF, 0);
    chk("coll_old", out1, 32'hE3A01005);
    step(1, 0, 32'h0, '0, 4'h0, 0);
    chk("coll_new", out1, 32'hDEADBEEF);

    // Reset with two fetches in flight
    step(1, 0, 32'h4, '0, 4'h0, 0);
    step(1, 0, 32'h8, '0, 4'h0, 0);
    #2;
    rst_n = 0;
    inst_read = 0;
    #1;
    chk("rst_mid_out1", out1, NOP);
    chk("rst_mid_v1",   {31'b0, v1}, 32'd0);
    chk("rst_mid_out2", out2, NOP);
    chk("rst_mid_v2",   {31'b0, v2}, 32'd0);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 32'h0, '0, 4'h0, 0);
      chk("rst_no_stale_v1", {31'b0, v1}, 32'd0);
      chk("rst_no_stale_v2", {31'b0, v2}, 32'd0);
    end
    step(1, 0, 32'h0, '0, 4'h0, 0);
    chk("rst_intact_0", out1, 32'hDEADBEEF);
    step(1, 0, 32'h8, '0, 4'h0, 0);
    chk("rst_intact_8", out1, 32'hEAFFFFFE);
    chk("rst_l2_0",     out2, 32'hDEADBEEF);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      r = $urandom_range(0, 15);
      if (r == 0)      a = {22'b0, $urandom_range(0, 255) % 256 == 0 ? 8'd1 : 8'($urandom), 2'b00} | 32'($urandom_range(1, 3));
      else if (r == 1) a = (32'h400 + ($urandom & 32'h0000_0FFC)) | ($urandom_range(0, 1) ? 32'h8000_0000 : 32'h0);
      else             a = {22'b0, 8'($urandom), 2'b00};
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, a, $urandom,
           4'($urandom), $urandom_range(0, 4) == 0);
    end
    step(0, 0, 32'h0, '0, 4'h0, 0);
    step(0, 0, 32'h0, '0, 4'h0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/inst_mem_pipe.md
# inst_mem_pipe

Parametrised, synchronous instruction memory for the pipelined ARM core. It sits between the fetch stage and the program store. It supports a configurable word count, data width and read latency (1 or 2 cycles), and a fetch-stall hold. A byte-enabled write port is provided for program loading. Misaligned or out-of-range fetches return an ARM NOP, flagged with an error bit, so fetch never consumes garbage.

## Interface
- DATA_W, 32, instruction word width; multiple of 8.
- ADDR_W, 32, byte-address width.
- DEPTH, 256, number of words; power of two, ≥ 4.
- READ_LAT, 1, read latency in cycles; legal values are 1 or 2.
- NOP_WORD, 32'hE1A00000, word driven on reset and on error fetches (MOV r0,r0).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- inst_address  in  ADDR_W  byte address, used for both read and write.
- inst_read  in  1  fetch request.
- inst_write  in  1  write request.
- inst_write_data  in  DATA_W  write data.
- inst_byte_en  in  DATA_W/8  per-byte write enable; bit i covers bits [8i+7:8i].
- stall  in  1  freezes the read pipeline.
- inst_out  out  DATA_W  fetched instruction.
- inst_valid  out  1  inst_out carries the result of an accepted fetch this cycle.
- inst_err  out  1  the fetch in inst_out was misaligned or out of range.
- wr_err  out  1  one-cycle pulse: the previous write was rejected.

## Operation
Address decode:
- Word index = inst_address[$clog2(DEPTH)+1:2].
- misaligned = inst_address[1:0] != 0.
- out_of_range = any address bit above the index field is nonzero.
- bad = misaligned | out_of_range.

Read path:
- A fetch is accepted on a rising edge where inst_read=1 and stall=0.
- The array is read on the accept edge.
- If bad, the word is replaced by NOP_WORD and an err tag is carried alongside it.
- READ_LAT=2 adds one output register stage. Each stage carries {data, valid, err}.
- When stall=0 and inst_read=0, a bubble (valid=0) enters the pipe.
- On bubble exit, inst_out holds its last value and inst_valid=0.
- While stall=1:
  - Every pipeline stage holds.
  - inst_out, inst_valid and inst_err stay constant.
  - inst_read is ignored; a request is not queued.

Write path:
- A write occurs on the rising edge with inst_write=1. It is independent of stall.
- Only bytes with inst_byte_en set are updated.
- If bad, the array is unchanged and wr_err=1 for exactly the next cycle.
- inst_write=1 with inst_byte_en=0 is a legal no-op with no error.

Simultaneous read and write on the same edge to the same word:
- Read-before-write: the fetch returns the old contents.
- The new data is visible to fetches accepted on later edges.

Reset (rst_n=0, asynchronous):
- inst_out=NOP_WORD, inst_valid=0, inst_err=0, wr_err=0. All pipeline stages clear to {NOP_WORD, 0, 0}.
- Array contents are not cleared.
- Reset asserted mid-operation discards in-flight fetches; none emerge after release.
- The first accept is the first rising edge with rst_n=1, inst_read=1 and stall=0.

## Timing
- READ_LAT=1: a fetch accepted at edge N is on inst_out/inst_valid/inst_err after edge N, readable in cycle N+1.
- READ_LAT=2: the same fetch appears after edge N+1.
- Each stall cycle adds one cycle to the latency of every in-flight fetch.
- Throughput: one fetch per unstalled cycle, with back-to-back addresses supported.
- wr_err rises after the offending write edge and falls after the next edge.
- There is no combinational path from any input to any output.

## Test plan
- **Load and fetch (READ_LAT=1).**
  - Stimulus: write 32'hE3A01005 @0x0, 32'hE2811001 @0x4, 32'hEAFFFFFE @0x8 (byte_en=4'hF), then fetch 0x0, 0x4, 0x8 on consecutive cycles.
  - Required: inst_out shows the three words in order on three consecutive cycles, each 1 cycle after its accept, with inst_valid=1 and inst_err=0.
- **Same sequence with READ_LAT=2.**
  - Required: identical data, each word 2 cycles after its accept, and no gaps between words.
- **Byte-enable merge.**
  - Stimulus: word @0x10 = 32'h11223344, then write 32'hAABBCCDD with byte_en=4'b0101, then fetch 0x10.
  - Required: inst_out = 32'h11BB33DD.
- **Error handling.**
  - Stimulus: fetch 0x6, then fetch 0x400 with DEPTH=256.
  - Required: for both, inst_out=32'hE1A00000, inst_valid=1, inst_err=1.
  - Stimulus: write to 0x2.
  - Required: wr_err pulses for 1 cycle and word 0x0 is unchanged.
- **Stall.**
  - Stimulus: with READ_LAT=2, issue fetches 0x0 and 0x4, then hold stall=1 for 3 cycles with inst_read=1 @0x8.
  - Required: outputs frozen for the 3 stalled cycles, 0x8 not fetched during the stall, remaining in-flight fetches resume in order after stall drops.
- **Collision and reset.**
  - Stimulus: on one edge, fetch 0x0 and write 32'hDEADBEEF @0x0.
  - Required: that fetch returns the old word; the next fetch of 0x0 returns 32'hDEADBEEF.
  - Stimulus: assert rst_n=0 while 2 fetches are in flight.
  - Required: immediately inst_out=NOP_WORD and inst_valid=0; no stale fetch appears after release; array contents are intact.
